bcd_to_bin: RTL

Sequential BCD-to-binary converter. It accepts a packed multi-digit BCD word through a valid/ready handshake and processes one digit per clock, most-significant digit first, using `acc = acc*10 + digit`. It then presents the binary result through a second valid/ready handshake. The block sits on the input side of the datapath and is the inverse of the binary-to-BCD display conversion: it turns keypad/switch BCD entry into binary operands.

---
 rtl/bcd_to_bin_if.sv | 27 ++
 rtl/bcd_to_bin.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if: handshake bundle for the BCD-to-binary converter.
// Input side carries a packed BCD word (valid_i/ready_o). Output side
// carries the binary result and error flag (valid_o/ready_i).
interface bcd_to_bin_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                  valid_i;
  logic                  ready_o;
  logic [4*DIGITS-1:0]   bcd_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [BIN_W-1:0]      bin_o;
  logic                  err_o;

  // Upstream producer and downstream consumer, seen from outside the converter
  modport master (
    output valid_i, bcd_i, ready_i,
    input  ready_o, valid_o, bin_o, err_o
  );

  // The converter itself
  modport slave (
    input  valid_i, bcd_i, ready_i,
    output ready_o, valid_o, bin_o, err_o
  );
endinterface

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter.
// Takes a packed DIGITS-digit BCD word and consumes one digit per clock,
// MSD first, as acc = acc*10 + digit. It then holds the binary result
// until the downstream takes it.
// Optional feature: define BCD2BIN_DIGIT_CHECK_EN to flag digits > 9.
// With the flag set, err_o=1 and bin_o=0. Without the macro, err_o is
// tied low and out-of-range digits are used as-is.
module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_to_bin_if.slave       bus
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [SR_W-1:0]   shift;
  logic [CNT_W-1:0]  count;
  logic [BIN_W-1:0]  acc;
  logic [BIN_W-1:0]  acc_next;
  logic [BIN_W-1:0]  result;
  logic [BIN_W-1:0]  bin_q;
  logic [3:0]        digit;
  logic              ready_q;
  logic              valid_q;
  logic              accept;
  logic              last_digit;

  assign digit = shift[SR_W-1 -: 4];

  // acc*10 is built as (acc<<3)+(acc<<1). Only the low BIN_W bits of the
  // wide sum survive truncation, and those low bits do not depend on any
  // carries above them, so the whole sum can be formed at BIN_W bits.
  assign acc_next = (acc << 3) + (acc << 1) + BIN_W'(digit);

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic err_flag;
  logic err_next;

  assign err_next = err_flag | (digit > 4'd9);

  // Sticky error flag: cleared when a word is accepted, and it collects
  // out-of-range digits during CONV. It then stays frozen through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
    end else if (accept) begin
      err_flag <= 1'b0;
    end else if (state == CONV) begin
      err_flag <= err_next;
    end
  end

  assign result    = err_next ? '0 : acc_next;
  assign bus.err_o = err_flag;
`else
  assign result    = acc_next;
  assign bus.err_o = 1'b0;
`endif

  // Next-state decode: accept in IDLE, count digits in CONV, wait for the
  // consumer in DONE
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_digit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid_i && ready_q) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (count == '0) begin
          last_digit = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered handshake outputs derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
      valid_q <= (state_next == DONE);
    end
  end

  // Datapath: load the word on accept, then shift and accumulate one digit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      count <= '0;
      acc   <= '0;
      bin_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift <= bus.bcd_i;
            count <= CNT_W'(DIGITS - 1);
            acc   <= '0;
          end
        end
        CONV: begin
          acc   <= acc_next;
          shift <= shift << 4;
          if (last_digit) begin
            bin_q <= result;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.bin_o   = bin_q;

endmodule
